// File: rtl/rr_mux4.sv
// rr_mux4: round-robin merge of four valid/ready channels into a one-entry
// registered output stream, each word tagged with its source channel index.
module rr_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_0,
    input  logic             in_valid_1,
    input  logic             in_valid_2,
    input  logic             in_valid_3,
    input  logic [WIDTH-1:0] in_data_0,
    input  logic [WIDTH-1:0] in_data_1,
    input  logic [WIDTH-1:0] in_data_2,
    input  logic [WIDTH-1:0] in_data_3,
    output logic             in_ready_0,
    output logic             in_ready_1,
    output logic             in_ready_2,
    output logic             in_ready_3,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    logic [3:0]       valid_s;
    logic [3:0]       ready_s;
    logic [1:0]       grant_s;
    logic             grant_vld_s;
    logic             can_accept_s;
    logic             take_s;
    logic [WIDTH-1:0] grant_data_s;
    logic [1:0]       last_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [1:0]       out_sel_r;

    assign valid_s      = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};
    assign can_accept_s = !out_valid_r || out_ready;
    assign take_s       = grant_vld_s && can_accept_s;

    // Round-robin grant: first valid channel scanning upward from last_r+1.
    // The scan runs backwards so the nearest candidate is written last and wins.
    always_comb begin
        logic [1:0] idx;
        idx         = 2'd0;
        grant_s     = 2'd0;
        grant_vld_s = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            idx         = last_r + 2'(k);
            grant_s     = valid_s[idx] ? idx : grant_s;
            grant_vld_s = valid_s[idx] | grant_vld_s;
        end
    end

    // Data selection for the granted channel.
    always_comb begin
        grant_data_s = in_data_0;
        case (grant_s)
            2'd0:    grant_data_s = in_data_0;
            2'd1:    grant_data_s = in_data_1;
            2'd2:    grant_data_s = in_data_2;
            2'd3:    grant_data_s = in_data_3;
            default: grant_data_s = in_data_0;
        endcase
    end

    // Ready goes only to the granted channel; forced low while reset is held.
    always_comb begin
        ready_s = 4'b0000;
        if (rst_n && take_s) begin
            ready_s[grant_s] = 1'b1;
        end else begin
            ready_s = 4'b0000;
        end
    end

    assign in_ready_0 = ready_s[0];
    assign in_ready_1 = ready_s[1];
    assign in_ready_2 = ready_s[2];
    assign in_ready_3 = ready_s[3];

    // Output register and priority pointer; reload takes precedence over drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= 2'd0;
            last_r      <= 2'd3;
        end else if (take_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_sel_r   <= grant_s;
            last_r      <= grant_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_mux4.sv
// tb_rr_mux4: vector table plus hand sequences and a random soak, all checked
// against a round-robin reference model feeding an expected-word queue.
module tb_rr_mux4;

    logic       clk;
    logic       rst_n;
    logic [3:0] vld;
    logic [7:0] dat [4];
    logic       ordy;
    logic [3:0] rdy;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_sel;

    rr_mux4 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_0(vld[0]), .in_valid_1(vld[1]), .in_valid_2(vld[2]), .in_valid_3(vld[3]),
        .in_data_0(dat[0]), .in_data_1(dat[1]), .in_data_2(dat[2]), .in_data_3(dat[3]),
        .in_ready_0(rdy[0]), .in_ready_1(rdy[1]), .in_ready_2(rdy[2]), .in_ready_3(rdy[3]),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_sel;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } ent_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    ent_t       q[$];
    logic       m_valid;
    logic [1:0] m_last;
    int         xfer_ch;
    logic       soak;
    logic [5:0] icnt [4];
    logic [5:0] ocnt [4];
    logic [3:0] s_rdy;
    logic       s_ov;
    logic [1:0] s_sel;
    logic [7:0] s_data;
    vec_t       tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model checks at negedge, model update at posedge, return at posedge+1.
    task automatic cycle();
        logic [3:0] er;
        logic       gv;
        logic [1:0] g;
        logic [1:0] idx;
        logic       acc;
        @(negedge clk);
        gv = 1'b0;
        g  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = m_last + 2'(k);
            if (!gv && vld[idx]) begin
                gv = 1'b1;
                g  = idx;
            end
        end
        acc = !m_valid || ordy;
        er  = 4'b0000;
        if (gv && acc) er[g] = 1'b1;
        chk("in_ready", 64'(rdy), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid && q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].data));
            chk("out_sel", 64'(out_sel), 64'(q[0].sel));
        end
        if (soak && out_valid && ordy) begin
            chk("soak_order", 64'(out_data), 64'({out_sel, ocnt[out_sel]}));
            ocnt[out_sel] = ocnt[out_sel] + 6'd1;
        end
        s_rdy  = rdy;
        s_ov   = out_valid;
        s_sel  = out_sel;
        s_data = out_data;
        @(posedge clk);
        xfer_ch = -1;
        if (m_valid && ordy && q.size() > 0) void'(q.pop_front());
        if (gv && acc) begin
            q.push_back('{sel: g, data: dat[g]});
            m_last  = g;
            xfer_ch = int'(g);
        end
        m_valid = (gv && acc) || (m_valid && !ordy);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_last  = 2'd3;
    endtask

    initial begin
        soak = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dat[i]  = 8'h10 + 8'(i);
            icnt[i] = 6'd0;
            ocnt[i] = 6'd0;
        end
        tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[7]  = '{4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0};
        tbl[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd1};
        tbl[9]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        // Power-on reset with all channels requesting.
        model_reset();
        rst_n = 1'b0;
        vld   = 4'b1111;
        ordy  = 1'b1;
        #3;
        chk("rst_ready", 64'(rdy), 64'(4'b0000));
        chk("rst_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_data", 64'(out_data), 64'(8'h00));
        chk("rst_sel", 64'(out_sel), 64'(2'd0));
        vld = 4'b0000;
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: single channel, stall, pointer wrap and skip.
        for (int i = 0; i < 12; i++) begin
            vld  = tbl[i].vld;
            ordy = tbl[i].ordy;
            cycle();
            chk("tbl_ready", 64'(s_rdy), 64'(tbl[i].exp_rdy));
            chk("tbl_valid", 64'(s_ov), 64'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) begin
                chk("tbl_sel", 64'(s_sel), 64'(tbl[i].exp_sel));
                chk("tbl_data", 64'(s_data), 64'(8'h10 + 8'(tbl[i].exp_sel)));
            end
        end

        // Reset while a word is held.
        vld  = 4'b1111;
        ordy = 1'b1;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(1'b0));
        chk("midrst_data", 64'(out_data), 64'(8'h00));
        chk("midrst_sel", 64'(out_sel), 64'(2'd0));
        chk("midrst_ready", 64'(rdy), 64'(4'b0000));
        model_reset();
        rst_n = 1'b1;

        // Round robin with all channels held valid.
        cycle();
        chk("first_grant", 64'(s_rdy), 64'(4'b0001));
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_valid", 64'(s_ov), 64'(1'b1));
            chk("rr_sel", 64'(s_sel), 64'(k % 4));
        end

        // Backpressure: held word is channel 1, next must be channel 2.
        ordy = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cycle();
            chk("bp_sel", 64'(s_sel), 64'(2'd1));
            chk("bp_ready", 64'(s_rdy), 64'(4'b0000));
        end
        ordy = 1'b1;
        cycle();
        cycle();
        chk("bp_next", 64'(s_sel), 64'(2'd2));

        // Drain, then random soak with sequence-numbered words per channel.
        vld = 4'b0000;
        cycle();
        cycle();
        soak = 1'b1;
        for (int i = 0; i < 4; i++) dat[i] = {2'(i), icnt[i]};
        for (int n = 0; n < 10000; n++) begin
            cycle();
            for (int i = 0; i < 4; i++) begin
                if (xfer_ch == i) begin
                    icnt[i] = icnt[i] + 6'd1;
                    vld[i]  = 1'($urandom_range(1));
                end else if (!vld[i]) begin
                    vld[i] = 1'($urandom_range(1));
                end
                dat[i] = {2'(i), icnt[i]};
            end
            ordy = ($urandom_range(3) != 0);
        end
        vld  = 4'b0000;
        ordy = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("drain_valid", 64'(s_ov), 64'(1'b0));
        for (int i = 0; i < 4; i++) chk("soak_count", 64'(ocnt[i]), 64'(icnt[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
